// File: rtl/lz77_token_decoder_if.sv
// Token and output-byte streams of the LZ77 token decoder.
// The master side produces tokens and sinks bytes; the slave side is the decoder.
interface lz77_token_decoder_if #(
   parameter int INDEX_WIDTH  = 12,
   parameter int LENGTH_WIDTH = 3
);
   logic                    tokenValid;
   logic                    tokenReady;
   logic                    tokenIsMatch;
   logic [7:0]              tokenLiteral;
   logic [INDEX_WIDTH-1:0]  tokenMatchIndex;
   logic [LENGTH_WIDTH-1:0] tokenMatchLength;
   logic                    outValid;
   logic                    outReady;
   logic [7:0]              outByte;

   modport master (
      output tokenValid, tokenIsMatch, tokenLiteral, tokenMatchIndex, tokenMatchLength, outReady,
      input  tokenReady, outValid, outByte
   );

   modport slave (
      input  tokenValid, tokenIsMatch, tokenLiteral, tokenMatchIndex, tokenMatchLength, outReady,
      output tokenReady, outValid, outByte
   );
endinterface

// File: rtl/lz77_token_decoder.sv
// Rebuilds one page from literal/match tokens into a history buffer and
// streams the reconstructed bytes out on a valid/ready channel.
module lz77_token_decoder #(
   parameter int PAGE_BYTES   = 4096,
   parameter int INDEX_WIDTH  = 12,
   parameter int LENGTH_WIDTH = 3
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 newPage,
   lz77_token_decoder_if.slave  bus,
   output logic [INDEX_WIDTH:0] bytesWritten,
   output logic                 pageDone,
   output logic                 errorFlag
);
   localparam logic [INDEX_WIDTH:0] PAGE_END = (INDEX_WIDTH + 1)'(PAGE_BYTES);

   typedef enum logic [1:0] {ACCEPT, COPY, DONE} state_t;

   state_t                  state_q;
   logic [INDEX_WIDTH:0]    wp_q;
   logic [INDEX_WIDTH:0]    wp_d;
   logic [INDEX_WIDTH-1:0]  src_q;
   logic [LENGTH_WIDTH-1:0] rem_q;
   logic                    out_valid_q;
   logic [7:0]              out_byte_q;
   logic [7:0]              byte_d;
   logic                    page_done_q;
   logic                    error_q;
   logic [7:0]              history [PAGE_BYTES];

   logic slot_free;
   logic token_ready;
   logic accept;
   logic match_legal;
   logic match_ok;
   logic match_bad;
   logic lit_load;
   logic copy_load;
   logic load;
   logic last_copy;

   assign slot_free   = !out_valid_q || bus.outReady;
   assign token_ready = (state_q == ACCEPT) && slot_free && !reset && !newPage;
   assign accept      = bus.tokenValid && token_ready;
   assign match_legal = (bus.tokenMatchLength != '0) && ({1'b0, bus.tokenMatchIndex} < wp_q);
   assign match_ok    = accept && bus.tokenIsMatch && match_legal;
   assign match_bad   = accept && bus.tokenIsMatch && !match_legal;
   assign lit_load    = accept && !bus.tokenIsMatch;
   assign copy_load   = (state_q == COPY) && slot_free && !newPage && !reset;
   assign load        = lit_load || copy_load;
   // src always trails wp, so the read never sees the byte written this same cycle
   assign byte_d      = copy_load ? history[src_q] : bus.tokenLiteral;
   assign wp_d        = wp_q + 1'b1;
   assign last_copy   = (rem_q == LENGTH_WIDTH'(1));

   always_ff @(posedge clock) begin
      if (load) begin
         history[wp_q[INDEX_WIDTH-1:0]] <= byte_d;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ACCEPT;
         wp_q        <= '0;
         out_valid_q <= 1'b0;
         out_byte_q  <= '0;
         page_done_q <= 1'b0;
         error_q     <= 1'b0;
      end else if (newPage) begin
         // any copy in flight is abandoned; a byte already on the output still drains
         state_q     <= ACCEPT;
         wp_q        <= '0;
         page_done_q <= 1'b0;
         error_q     <= 1'b0;
         if (slot_free) begin
            out_valid_q <= 1'b0;
         end
      end else begin
         if (slot_free) begin
            out_valid_q <= load;
            if (load) begin
               out_byte_q <= byte_d;
            end
         end
         if (load) begin
            wp_q <= wp_d;
         end
         unique case (state_q)
            ACCEPT: begin
               if (match_ok) begin
                  src_q   <= bus.tokenMatchIndex;
                  rem_q   <= bus.tokenMatchLength;
                  state_q <= COPY;
               end
               if (match_bad) begin
                  error_q <= 1'b1;
               end
               if (lit_load && (wp_d == PAGE_END)) begin
                  state_q     <= DONE;
                  page_done_q <= 1'b1;
               end
            end
            COPY: begin
               if (copy_load) begin
                  src_q <= src_q + 1'b1;
                  rem_q <= rem_q - 1'b1;
                  if (wp_d == PAGE_END) begin
                     state_q     <= DONE;
                     page_done_q <= 1'b1;
                     if (!last_copy) begin
                        error_q <= 1'b1;
                     end
                  end else if (last_copy) begin
                     state_q <= ACCEPT;
                  end
               end
            end
            DONE: begin
               state_q <= DONE;
            end
            default: begin
               state_q <= ACCEPT;
            end
         endcase
      end
   end

   assign bus.tokenReady = token_ready;
   assign bus.outValid   = out_valid_q;
   assign bus.outByte    = out_byte_q;
   assign bytesWritten   = wp_q;
   assign pageDone       = page_done_q;
   assign errorFlag      = error_q;
endmodule

// File: tb/tb_lz77_token_decoder.sv
// Randomized and directed bench for lz77_token_decoder against a page-array
// model that applies each accepted token with plain array arithmetic.
module tb_lz77_token_decoder;
   logic        clock = 1'b0;
   logic        reset;
   logic        newPage;
   logic [12:0] bytesWritten;
   logic        pageDone;
   logic        errorFlag;

   lz77_token_decoder_if bus ();

   lz77_token_decoder dut (
      .clock       (clock),
      .reset       (reset),
      .newPage     (newPage),
      .bus         (bus),
      .bytesWritten(bytesWritten),
      .pageDone    (pageDone),
      .errorFlag   (errorFlag)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   bit bp_mode  = 1'b0;

   logic [7:0] mpage [4096];
   int         mwp;
   bit         merr;
   logic [7:0] exp_q [$];
   logic [7:0] got_q [$];
   int         got_cyc [$];

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (!reset && bus.outValid && bus.outReady) begin
         got_q.push_back(bus.outByte);
         got_cyc.push_back(cyc);
      end
   end

   initial begin
      forever begin
         @(posedge clock);
         #1;
         if (bp_mode) bus.outReady = ($urandom_range(3, 0) != 0);
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: a page array plus write count; bytes beyond the page end are dropped and flagged.
   task automatic model_token(input bit m, input logic [7:0] lit, input logic [11:0] idx,
                              input logic [2:0] len);
      int s;
      s = int'(idx);
      if (mwp >= 4096) return;
      if (!m) begin
         mpage[mwp] = lit;
         exp_q.push_back(lit);
         mwp++;
      end else if (len == 0 || s >= mwp) begin
         merr = 1'b1;
      end else begin
         for (int k = 0; k < int'(len); k++) begin
            if (mwp == 4096) begin
               merr = 1'b1;
               break;
            end
            mpage[mwp] = mpage[s + k];
            exp_q.push_back(mpage[mwp]);
            mwp++;
         end
      end
   endtask

   task automatic clear_streams();
      exp_q.delete();
      got_q.delete();
      got_cyc.delete();
   endtask

   task automatic send_token(input bit m, input logic [7:0] lit, input logic [11:0] idx,
                             input logic [2:0] len, output int hs);
      bit done;
      done = 1'b0;
      hs   = -1;
      bus.tokenIsMatch     = m;
      bus.tokenLiteral     = lit;
      bus.tokenMatchIndex  = idx;
      bus.tokenMatchLength = len;
      bus.tokenValid       = 1'b1;
      for (int w = 0; w < 64 && !done; w++) begin
         @(negedge clock);
         if (bus.tokenReady) begin
            done = 1'b1;
            hs   = cyc;
            model_token(m, lit, idx, len);
         end
         @(posedge clock);
         #1;
      end
      bus.tokenValid = 1'b0;
      if (!done) check("token_accept_timeout", 0, 1);
   endtask

   task automatic do_new_page();
      clear_streams();
      newPage = 1'b1;
      @(posedge clock);
      #1;
      newPage = 1'b0;
      mwp     = 0;
      merr    = 1'b0;
   endtask

   task automatic drain(input string tag);
      bit done;
      int n;
      done = 1'b0;
      bp_mode = 1'b0;
      bus.outReady = 1'b1;
      for (int w = 0; w < 300 && !done; w++) begin
         @(posedge clock);
         #3;
         if (got_q.size() >= exp_q.size() && !bus.outValid) done = 1'b1;
      end
      if (!done) check({tag, "_drain_timeout"}, 0, 1);
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check({tag, "_byte"}, got_q[i], exp_q[i]);
         if (got_q[i] !== exp_q[i]) break;
      end
      check({tag, "_count"}, got_q.size(), exp_q.size());
      check({tag, "_bytesWritten"}, bytesWritten, mwp);
      check({tag, "_errorFlag"}, errorFlag, merr);
      check({tag, "_pageDone"}, pageDone, (mwp == 4096));
   endtask

   initial begin
      int hs;
      int hs0;
      logic [11:0] ridx;
      logic [2:0]  rlen;

      reset = 1'b1;
      newPage = 1'b0;
      bus.outReady = 1'b1;
      bus.tokenValid = 1'b1;
      bus.tokenIsMatch = 1'b0;
      bus.tokenLiteral = 8'hEE;
      bus.tokenMatchIndex = '0;
      bus.tokenMatchLength = '0;
      mwp = 0;
      merr = 1'b0;
      @(negedge clock);
      check("reset_tokenReady", bus.tokenReady, 0);
      @(posedge clock);
      #1;
      check("reset_outValid", bus.outValid, 0);
      check("reset_outByte", bus.outByte, 0);
      check("reset_bytesWritten", bytesWritten, 0);
      check("reset_pageDone", pageDone, 0);
      check("reset_errorFlag", errorFlag, 0);
      bus.tokenValid = 1'b0;
      reset = 1'b0;
      @(posedge clock);
      #1;

      // three back-to-back literals
      do_new_page();
      send_token(0, 8'h41, 12'd0, 3'd0, hs0);
      send_token(0, 8'h42, 12'd0, 3'd0, hs);
      send_token(0, 8'h43, 12'd0, 3'd0, hs);
      drain("lit3");
      check("lit_latency", got_cyc[0] - hs0, 1);
      check("lit_back_to_back", got_cyc[2] - got_cyc[0], 2);
      check("lit3_byte2", got_q[2], 8'h43);
      check("lit3_bw", bytesWritten, 3);

      // ABCD then copy of BCD
      do_new_page();
      send_token(0, 8'h41, 12'd0, 3'd0, hs);
      send_token(0, 8'h42, 12'd0, 3'd0, hs);
      send_token(0, 8'h43, 12'd0, 3'd0, hs);
      send_token(0, 8'h44, 12'd0, 3'd0, hs);
      send_token(1, 8'h00, 12'd1, 3'd3, hs);
      drain("abcd");
      check("match_latency", got_cyc[4] - hs, 2);
      check("abcd_byte4", got_q[4], 8'h42);
      check("abcd_byte6", got_q[6], 8'h44);

      // overlapping run-length copy
      do_new_page();
      send_token(0, 8'h5A, 12'd0, 3'd0, hs);
      send_token(1, 8'h00, 12'd0, 3'd7, hs);
      drain("rle");
      check("rle_count8", got_q.size(), 8);
      check("rle_byte7", got_q[7], 8'h5A);
      check("rle_err", errorFlag, 0);

      // backpressure in the middle of a copy
      do_new_page();
      send_token(0, 8'h10, 12'd0, 3'd0, hs);
      send_token(0, 8'h20, 12'd0, 3'd0, hs);
      send_token(0, 8'h30, 12'd0, 3'd0, hs);
      send_token(0, 8'h40, 12'd0, 3'd0, hs);
      send_token(1, 8'h00, 12'd0, 3'd7, hs);
      @(posedge clock);
      #1;
      @(posedge clock);
      #1;
      bus.outReady = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check("bp_outValid", bus.outValid, 1);
         check("bp_hold", bus.outByte, exp_q[got_q.size()]);
         check("bp_tokenReady", bus.tokenReady, 0);
         @(posedge clock);
         #1;
      end
      drain("bp");

      // illegal match: index not yet written
      do_new_page();
      for (int i = 1; i <= 4; i++) send_token(0, 8'(i), 12'd0, 3'd0, hs);
      send_token(1, 8'h00, 12'd4, 3'd2, hs);
      check("illegal_err", errorFlag, 1);
      send_token(0, 8'h99, 12'd0, 3'd0, hs);
      drain("illegal");
      check("illegal_bw", bytesWritten, 5);

      // page fill with truncated copy
      do_new_page();
      for (int i = 0; i < 4094; i++) send_token(0, 8'($urandom), 12'd0, 3'd0, hs);
      send_token(1, 8'h00, 12'd0, 3'd7, hs);
      drain("full");
      check("full_pageDone", pageDone, 1);
      check("full_err", errorFlag, 1);
      check("full_bw", bytesWritten, 4096);
      bus.tokenIsMatch = 1'b0;
      bus.tokenLiteral = 8'h66;
      bus.tokenValid = 1'b1;
      @(negedge clock);
      check("full_tokenReady", bus.tokenReady, 0);
      @(posedge clock);
      #1;
      clear_streams();
      newPage = 1'b1;
      @(negedge clock);
      check("newpage_beats_token", bus.tokenReady, 0);
      @(posedge clock);
      #1;
      newPage = 1'b0;
      bus.tokenValid = 1'b0;
      mwp = 0;
      merr = 1'b0;
      check("np_bw", bytesWritten, 0);
      check("np_pageDone", pageDone, 0);
      check("np_err", errorFlag, 0);
      send_token(0, 8'h33, 12'd0, 3'd0, hs);
      drain("after_np");

      // reset in the middle of a copy
      do_new_page();
      send_token(0, 8'h77, 12'd0, 3'd0, hs);
      send_token(1, 8'h00, 12'd0, 3'd7, hs);
      @(posedge clock);
      #1;
      reset = 1'b1;
      @(negedge clock);
      check("rst_mid_tokenReady", bus.tokenReady, 0);
      @(posedge clock);
      #1;
      check("rst_mid_outValid", bus.outValid, 0);
      check("rst_mid_bw", bytesWritten, 0);
      reset = 1'b0;
      clear_streams();
      mwp = 0;
      merr = 1'b0;
      @(negedge clock);
      check("rst_mid_accept", bus.tokenReady, 1);
      @(posedge clock);
      #1;
      send_token(0, 8'h11, 12'd0, 3'd0, hs);
      drain("after_rst");

      // random token stream with random backpressure
      do_new_page();
      bp_mode = 1'b1;
      for (int t = 0; t < 400; t++) begin
         if ($urandom_range(9, 0) < 6 || mwp == 0) begin
            send_token(0, 8'($urandom), 12'd0, 3'd0, hs);
         end else if ($urandom_range(9, 0) == 0) begin
            if ($urandom_range(1, 0) == 0) begin
               ridx = 12'(mwp);
               rlen = 3'($urandom_range(7, 1));
            end else begin
               ridx = 12'($urandom_range(mwp - 1, 0));
               rlen = 3'd0;
            end
            send_token(1, 8'h00, ridx, rlen, hs);
         end else begin
            ridx = 12'($urandom_range(mwp - 1, 0));
            rlen = 3'($urandom_range(7, 1));
            send_token(1, 8'h00, ridx, rlen, hs);
         end
      end
      drain("random");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
